// File: rtl/aibcr3aux_osc_meas_ctrl.sv
// Tester-side sequencer for the oscillator DFT counter: timed enable
// window, settle, double read of the count code and limit check.
module aibcr3aux_osc_meas_ctrl #(
  parameter int SYNC_CYC   = 4,
  parameter int SETTLE_CYC = 4,
  parameter int RST_CYC    = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] win_len,
  input  logic [5:0] lim_lo,
  input  logic [5:0] lim_hi,
  input  logic [5:0] cntr_code,
  output logic       testpin_resetb,
  output logic       testpin_enable,
  output logic       busy,
  output logic       done,
  output logic [5:0] code_q,
  output logic       pass,
  output logic       unstable
);

  localparam int CW = 8;
  localparam logic [CW-1:0] SYNC_END = CW'(SYNC_CYC - 1);
  localparam logic [CW-1:0] SETL_END = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] RST_SAT  = CW'(RST_CYC);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WIN,
    SETTLE,
    CAPT1,
    CAPT2,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] lowcnt_q, lowcnt_d;
  logic [3:0]    wlen_q, wlen_d;
  logic [5:0]    lo_q, lo_d;
  logic [5:0]    hi_q, hi_d;
  logic [5:0]    samp_q, samp_d;
  logic          rstb_q, rstb_d;
  logic          en_q, en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [5:0]    code_q_q, code_d;
  logic          pass_q, pass_d;
  logic          unst_q, unst_d;

  logic in_lim;
  logic same;

  assign in_lim = (cntr_code >= lo_q) && (cntr_code <= hi_q);
  assign same   = (cntr_code == samp_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lowcnt_d = lowcnt_q;
    wlen_d   = wlen_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    samp_d   = samp_q;
    rstb_d   = rstb_q;
    en_d     = en_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    code_d   = code_q_q;
    pass_d   = pass_q;
    unst_d   = unst_q;
    unique case (state_q)
      IDLE: begin
        rstb_d = 1'b0;
        en_d   = 1'b0;
        busy_d = 1'b0;
        if (start && !abort && lowcnt_q == RST_SAT) begin
          state_d  = ARM;
          cnt_d    = '0;
          lowcnt_d = '0;
          wlen_d   = win_len;
          lo_d     = lim_lo;
          hi_d     = lim_hi;
          rstb_d   = 1'b1;
          busy_d   = 1'b1;
        end else if (lowcnt_q != RST_SAT) begin
          lowcnt_d = lowcnt_q + 1'b1;
        end
      end
      ARM: begin
        if (cnt_q == SYNC_END) begin
          state_d = WIN;
          cnt_d   = '0;
          en_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WIN: begin
        if (cnt_q == {4'b0, wlen_q}) begin
          state_d = SETTLE;
          cnt_d   = '0;
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == SETL_END) begin
          state_d = CAPT1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CAPT1: begin
        samp_d  = cntr_code;
        state_d = CAPT2;
      end
      CAPT2: begin
        // 63 is the counter's saturation code, never a valid pass
        code_d  = cntr_code;
        unst_d  = !same;
        pass_d  = same && in_lim && (cntr_code != 6'd63);
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d  = IDLE;
        rstb_d   = 1'b0;
        lowcnt_d = '0;
      end
      default: begin
        state_d  = IDLE;
        rstb_d   = 1'b0;
        en_d     = 1'b0;
        busy_d   = 1'b0;
        lowcnt_d = '0;
      end
    endcase
    if (abort && state_q != IDLE) begin
      state_d  = IDLE;
      cnt_d    = '0;
      lowcnt_d = '0;
      rstb_d   = 1'b0;
      en_d     = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      code_d   = code_q_q;
      pass_d   = pass_q;
      unst_d   = unst_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      lowcnt_q <= '0;
      wlen_q   <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      samp_q   <= '0;
      rstb_q   <= 1'b0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      code_q_q <= '0;
      pass_q   <= 1'b0;
      unst_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lowcnt_q <= lowcnt_d;
      wlen_q   <= wlen_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      samp_q   <= samp_d;
      rstb_q   <= rstb_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      code_q_q <= code_d;
      pass_q   <= pass_d;
      unst_q   <= unst_d;
    end
  end

  assign testpin_resetb = rstb_q;
  assign testpin_enable = en_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign code_q         = code_q_q;
  assign pass           = pass_q;
  assign unstable       = unst_q;

endmodule
